// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the execute-side queues.
// Instruction/writeback formats plus reservation-station sizing.
package uarch_pkg;

    localparam int PIPE_WIDTH = 3;
    localparam int TAG_W      = 6;
    localparam int XLEN       = 32;

    localparam int RS_DEPTH = 4;
    typedef logic [$clog2(RS_DEPTH)-1:0] rs_idx_t;

    typedef struct packed {
        logic             is_renamed;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } source_t;

    typedef struct packed {
        logic             is_valid;
        logic [XLEN-1:0]  pc;
        logic [7:0]       opcode;
        logic [TAG_W-1:0] dest_tag;
        source_t          src_0_a;
        source_t          src_0_b;
        source_t          src_1_a;
        source_t          src_1_b;
    } instruction_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;

endpackage

// File: rtl/rs_age_select.sv
// Age-matrix oldest-first selector for the reservation station.
// older[i][j]=1 means entry i was allocated before entry j.
module rs_age_select #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] issue,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             grant_valid
);

    logic [DEPTH-1:0] older [DEPTH];
    logic [DEPTH-1:0] col;

    // Rows of free entries may keep stale bits; they are harmless because
    // selection is masked by ready, and the row is cleared on allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i == j || issue[i] || issue[j]) begin
                        older[i][j] <= 1'b0;
                    end else if (alloc[i]) begin
                        older[i][j] <= 1'b0;
                    end else if (alloc[j]) begin
                        older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        col   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            col = '0;
            for (int j = 0; j < DEPTH; j++) col[j] = older[j][i];
            grant[i] = ready[i] && ((col & ready) == '0);
        end
    end

    assign grant_valid = |grant;

endmodule

// File: rtl/rs_ooo_queue.sv
// Multi-entry reservation station: buffers dispatched instructions, wakes
// renamed sources from the CDB and issues the oldest ready entry.
module rs_ooo_queue
    import uarch_pkg::*;
#(
    parameter int   DEPTH   = RS_DEPTH,
    parameter int   NUM_CDB = PIPE_WIDTH,
    localparam int  IDX_W   = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             cache_stall,
    input  instruction_t                     rs_entry,
    input  logic                             rs_we,
    output logic                             rs_write_rdy,
    output logic                             rs_read_rdy,
    output instruction_t                     execute_pkt,
    input  logic                             alu_re,
    input  writeback_packet_t [NUM_CDB-1:0]  cdb_ports,
    output logic [IDX_W:0]                   occupancy
);

    instruction_t     slots [DEPTH];
    instruction_t     woken [DEPTH];
    instruction_t     entry_in;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] issue_oh;
    logic [DEPTH-1:0] grant;
    logic             grant_valid;
    logic             alloc_fire;
    logic             issue_fire;
    logic [IDX_W:0]   occupancy_next;

    // Descending scan so that the lowest matching port is applied last and wins.
    function automatic source_t wake_src(input source_t s,
                                         input writeback_packet_t [NUM_CDB-1:0] cdb);
        wake_src = s;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (s.is_renamed && cdb[p].valid && cdb[p].tag == s.tag) begin
                wake_src.data       = cdb[p].result;
                wake_src.is_renamed = 1'b0;
            end
        end
    endfunction

    function automatic instruction_t wake_instr(input instruction_t ins,
                                                input writeback_packet_t [NUM_CDB-1:0] cdb);
        wake_instr         = ins;
        wake_instr.src_0_a = wake_src(ins.src_0_a, cdb);
        wake_instr.src_0_b = wake_src(ins.src_0_b, cdb);
        wake_instr.src_1_a = wake_src(ins.src_1_a, cdb);
        wake_instr.src_1_b = wake_src(ins.src_1_b, cdb);
    endfunction

    always_comb begin
        entry_in = wake_instr(rs_entry, cdb_ports);
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake_instr(slots[i], cdb_ports);
            ready[i] = valid[i] && !slots[i].src_0_a.is_renamed
                                && !slots[i].src_0_b.is_renamed
                                && !slots[i].src_1_a.is_renamed
                                && !slots[i].src_1_b.is_renamed;
        end
    end

    always_comb begin
        free_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    assign rs_write_rdy = (occupancy < (IDX_W + 1)'(DEPTH));
    assign alloc_fire   = rs_we && rs_write_rdy && rs_entry.is_valid && !cache_stall && !flush;
    assign issue_fire   = grant_valid && alu_re && !flush;
    assign alloc_oh     = free_oh & {DEPTH{alloc_fire}};
    assign issue_oh     = grant & {DEPTH{issue_fire}};
    assign rs_read_rdy  = grant_valid;

    assign occupancy_next = occupancy + (IDX_W + 1)'(alloc_fire) - (IDX_W + 1)'(issue_fire);

    rs_age_select #(
        .DEPTH(DEPTH)
    ) u_age_select (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc      (alloc_oh),
        .issue      (issue_oh),
        .ready      (ready),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    always_comb begin
        execute_pkt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) execute_pkt = slots[i];
        end
    end

    // Stored payloads are snooped every cycle, so a broadcast lands at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (flush) begin
            valid     <= '0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    slots[i] <= entry_in;
                    valid[i] <= 1'b1;
                end else begin
                    if (issue_oh[i]) valid[i] <= 1'b0;
                    if (valid[i])    slots[i] <= woken[i];
                end
            end
            occupancy <= occupancy_next;
        end
    end

endmodule
